snes_ctrl: RTL
==============

# snes_ctrl

Memory-mapped SNES gamepad interface on the memory controller's 2-bit controller address port (`addr_ctrlr`). It generates the SNES latch/clock waveform, shifts in the 16-bit serial button word and keeps a current-state register and a sticky "newly pressed" register. It returns them to the CPU on the shared data-return path. Polling is either periodic (frame rate) or single-shot on CPU command.

## Interface
- `HALF_DIV`, 300: half-period of `snes_clk` in `clk` cycles; minimum 4.
- `POLL_DIV`, 833333: cycles between automatic polls (60 Hz at 50 MHz); minimum 64*`HALF_DIV`.
- `clk`  in  1  system clock; the block has a single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `addr`  in  2  register select from the memory controller (`addr_ctrlr`).
- `rd`  in  1  read strobe, one cycle.
- `wr`  in  1  write strobe, one cycle.
- `din`  in  16  write data (`DATAWIDTH`).
- `dout`  out  16  registered read data.
- `snes_latch`  out  1  pad latch; active-high.
- `snes_clk`  out  1  pad clock; idles high.
- `snes_data`  in  1  pad serial data; asynchronous, active-low.
- `done`  out  1  one-cycle pulse when a poll completes.

## Operation
- Register map:
  - 0: `buttons`. This is the current state, active-high. Bit n holds serial bit n: 0 B, 1 Y, 2 Select, 3 Start, 4-7 Up/Down/Left/Right, 8 A, 9 X, 10 L, 11 R, 12-15 unused (0 on a standard pad). Read-only.
  - 1: `pressed`. Sticky: each bit is OR'ed with `new & ~old` at every poll completion. A read clears it.
  - 2: status. Bit 15 is `busy` (FSM not IDLE), bit 14 is `enable`, bits 7:0 are a poll counter that wraps 255->0. Read-only.
  - 3: control, write-only; reads return 0. Bit 0 is `enable` (level, stored). Bit 1 is `start` (self-clearing; starts one poll if IDLE, ignored if busy).
- Writes to addresses 0-2 are ignored.
- `snes_data` passes through a 2-flop synchronizer before use.
- FSM states: IDLE, LATCH, CLK_LO, CLK_HI, DONE.
  - IDLE -> LATCH on `start`, or on poll-timer terminal count while `enable`=1.
  - LATCH: `snes_latch`=1 for 2*`HALF_DIV` cycles, then -> CLK_LO.
  - CLK_LO: `snes_clk`=0 for `HALF_DIV` cycles, then -> CLK_HI.
  - CLK_HI: `snes_clk`=1 for `HALF_DIV` cycles. Bit counter 0..15 increments; after the 16th pulse -> DONE, otherwise -> CLK_LO.
  - Sampling: bit n is sampled from the synchronized `snes_data` on the last cycle before entering the CLK_LO of pulse n. Bit 0 is sampled on the last LATCH cycle. Bit n>0 is sampled on the last CLK_HI cycle of pulse n-1. Samples are shifted LSB-first into a 16-bit shift register.
  - DONE (1 cycle): `buttons` <= ~shift, `pressed` updated, poll counter +1, `done`=1, -> IDLE.
- Poll timer: a free-running down-counter reloaded to `POLL_DIV`-1. It counts only while `enable`=1 and resets to `POLL_DIV`-1 when `enable` is cleared. A terminal count while busy is dropped, not queued.
- Clearing `enable` mid-poll lets that poll finish.
- Simultaneous DONE and read of `pressed`: read returns the pre-update value. After that cycle, `pressed` = newly set bits only (set wins over clear for those bits; all others clear).

## Timing
- Reset values: `dout`=0, `snes_latch`=0, `snes_clk`=1, `done`=0, `buttons`=0, `pressed`=0, `enable`=0, poll counter=0, FSM IDLE, shift=0, poll timer=`POLL_DIV`-1.
- `rst` asserted mid-poll aborts immediately: pins go to reset values asynchronously, and no `buttons` update occurs.
- Read latency: `dout` is valid the cycle after `rd` and holds until the next `rd`. `wr` and `rd` in the same cycle: both are performed.
- Poll duration: start accepted at edge k gives `snes_latch` high on cycles k+1 .. k+2H, where H=`HALF_DIV`. The 16 clock pulses span 32H cycles. DONE/`done` occurs at cycle k+34H+1, and `buttons` is readable from k+34H+2.
- `start` and terminal count in the same IDLE cycle produce a single poll.

## Test plan
- Reset, then read addresses 0, 1, 2, 3 -> all 0. Confirm `snes_clk`=1 and `snes_latch`=0.
- H=4 pad model driving serial word with B and Start pressed (serial bits 0 and 3 low, rest high); write 3 <= 0x0002 -> `snes_latch` high 8 cycles, 16 `snes_clk` low pulses of 4 cycles, `done` 137 cycles after write; read 0 = 0x0009, read 1 = 0x0009, read 1 again = 0x0000, read 2 = 0x0001.
- Second poll with only Start held -> `buttons`=0x0008, `pressed`=0x0000; then A pressed -> `pressed`=0x0100.
- `enable`=1, `POLL_DIV`=300 -> `done` every 300 cycles; write 3 <= 0x0003 while busy -> no extra poll, status bit 15 reads 1 mid-poll.
- Read of address 1 in the same cycle as `done`, with new press of X -> returns old value; next read returns 0x0200.
- Assert `rst` during CLK_LO of pulse 7 -> pins immediately at idle levels, `buttons` unchanged at 0, next `start` completes a full normal poll.

Source files
------------

// File: rtl/snes_ctrl.sv
// snes_ctrl -- memory-mapped SNES gamepad interface.
//
// Generates the pad latch/clock waveform, shifts in the 16-bit serial button
// word and keeps a current-state register plus a sticky "newly pressed"
// register for the CPU. Polls run periodically (poll timer) or on command.
//
// Parameters:
//   HALF_DIV  half-period of o_snes_clk in i_clk cycles (>= 4)
//   POLL_DIV  i_clk cycles between automatic polls (>= 64*HALF_DIV)
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_addr[1:0]  register select: 0 buttons, 1 pressed, 2 status, 3 control
//   i_rd         read strobe (one cycle), o_dout valid the following cycle
//   i_wr         write strobe (one cycle), only address 3 is writable
//   i_din[15:0]  write data; control bit 0 = enable, bit 1 = start
//   o_dout[15:0] registered read data, held until the next read
//   o_snes_latch pad latch, active-high
//   o_snes_clk   pad clock, idles high
//   i_snes_data  pad serial data, asynchronous, active-low
//   o_done       one-cycle pulse when a poll completes
module snes_ctrl #(
  parameter int unsigned HALF_DIV = 300,
  parameter int unsigned POLL_DIV = 833333
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_addr,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [15:0] i_din,
  output logic [15:0] o_dout,
  output logic        o_snes_latch,
  output logic        o_snes_clk,
  input  logic        i_snes_data,
  output logic        o_done
);

  localparam int unsigned CW = $clog2(2 * HALF_DIV);
  localparam int unsigned TW = $clog2(POLL_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CLK_LO,
    S_CLK_HI,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_val;
  logic            w_cnt_load;
  logic [3:0]      r_bit;
  logic            w_bit_inc;
  logic            w_sample;

  logic            r_sync1;
  logic            r_sync2;
  logic [15:0]     r_shift;
  logic [15:0]     r_buttons;
  logic [15:0]     r_pressed;
  logic [7:0]      r_polls;
  logic            r_enable;
  logic [TW-1:0]   r_timer;
  logic [15:0]     r_dout;

  logic            r_latch;
  logic            r_sclk;
  logic            r_done;

  logic            w_ctrl_wr;
  logic            w_start;
  logic            w_tc;
  logic            w_busy;
  logic            w_rd_pressed;
  logic [15:0]     w_new_press;
  logic [15:0]     w_rdata;
  logic            w_unused_din;

  assign w_unused_din = ^i_din[15:2];

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign w_ctrl_wr    = i_wr && (i_addr == 2'd3);
  assign w_start      = w_ctrl_wr && i_din[1];
  assign w_rd_pressed = i_rd && (i_addr == 2'd1);
  assign w_busy       = (r_state != S_IDLE);
  assign w_tc         = r_enable && (r_timer == '0);

  // Serial data is active-low, so a pressed button was shifted in as 0.
  assign w_new_press  = ~r_shift & ~r_buttons;

  always_comb begin
    w_rdata = '0;
    case (i_addr)
      2'd0:    w_rdata = r_buttons;
      2'd1:    w_rdata = r_pressed;
      2'd2:    w_rdata = {w_busy, r_enable, 6'd0, r_polls};
      default: w_rdata = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Poll FSM: next-state and timing control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_sample   = 1'b0;
    w_bit_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // start and a terminal count together still give a single poll
        if (w_start || w_tc) begin
          w_next     = S_LATCH;
          w_cnt_load = 1'b1;
          w_cnt_val  = CW'(2 * HALF_DIV - 1);
        end
      end
      S_LATCH: begin
        if (r_cnt == '0) begin
          w_next     = S_CLK_LO;
          w_cnt_load = 1'b1;
          w_cnt_val  = CW'(HALF_DIV - 1);
          w_sample   = 1'b1;
        end
      end
      S_CLK_LO: begin
        if (r_cnt == '0) begin
          w_next     = S_CLK_HI;
          w_cnt_load = 1'b1;
          w_cnt_val  = CW'(HALF_DIV - 1);
        end
      end
      S_CLK_HI: begin
        if (r_cnt == '0) begin
          w_bit_inc = 1'b1;
          if (r_bit == 4'd15) begin
            w_next = S_DONE;
          end else begin
            // last high cycle of pulse n-1 captures bit n
            w_next     = S_CLK_LO;
            w_cnt_load = 1'b1;
            w_cnt_val  = CW'(HALF_DIV - 1);
            w_sample   = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_cnt_load) begin
      r_cnt <= w_cnt_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit <= '0;
    end else if (r_state == S_IDLE) begin
      r_bit <= '0;
    end else if (w_bit_inc) begin
      r_bit <= r_bit + 1'b1;
    end
  end

  // Pad pins are registered from the next state so they change cleanly with
  // the state register and drop to idle levels on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_latch <= 1'b0;
      r_sclk  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_latch <= (w_next == S_LATCH);
      r_sclk  <= (w_next != S_CLK_LO);
      r_done  <= (w_next == S_DONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Serial input path
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_snes_data;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
    end else if (w_sample) begin
      r_shift <= {r_sync2, r_shift[15:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buttons <= '0;
      r_polls   <= '0;
    end else if (r_state == S_DONE) begin
      r_buttons <= ~r_shift;
      r_polls   <= r_polls + 1'b1;
    end
  end

  // A read coinciding with completion clears the old bits but keeps the new
  // presses, so nothing reported by this poll is lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pressed <= '0;
    end else if (r_state == S_DONE) begin
      r_pressed <= (w_rd_pressed ? '0 : r_pressed) | w_new_press;
    end else if (w_rd_pressed) begin
      r_pressed <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_enable <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_enable <= i_din[0];
    end
  end

  // Poll timer keeps running during a poll; a terminal count while busy is
  // simply lost because the FSM only looks at it in IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timer <= TW'(POLL_DIV - 1);
    end else if (!r_enable) begin
      r_timer <= TW'(POLL_DIV - 1);
    end else if (r_timer == '0) begin
      r_timer <= TW'(POLL_DIV - 1);
    end else begin
      r_timer <= r_timer - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dout <= '0;
    end else if (i_rd) begin
      r_dout <= w_rdata;
    end
  end

  assign o_dout       = r_dout;
  assign o_snes_latch = r_latch;
  assign o_snes_clk   = r_sclk;
  assign o_done       = r_done;

endmodule
